// File: rtl/serial_arith_pkg.sv
// Shared encodings for the bit-serial arithmetic units: FSM state values and
// operation modes.
package serial_arith_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit combinational full adder; the only arithmetic cell of the serial
// adder/subtractor.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a registered carry,
// processing WIDTH-bit operands LSB-first under a start/busy/done handshake.
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  // Handshake: start is honoured only in IDLE; busy is high for exactly the
  // WIDTH SHIFT cycles; done is a one-cycle pulse in DONE, the cycle in which
  // S/Cout/Ovf first show the new result.
  state_e           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, res, res_nxt;
  logic             carry;
  logic [CW-1:0]    count;
  logic             sum, co;

  full_adder_bit u_fa (
    .a (op_a[0]),
    .b (op_b[0]),
    .ci(carry),
    .s (sum),
    .co(co)
  );

  assign res_nxt = (res >> 1) | {sum, {(WIDTH-1){1'b0}}};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (count == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      count <= '0;
      S     <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtract is A + ~B + ~borrow, so mode is consumed here and never needed again.
            op_a  <= A;
            op_b  <= (mode == MODE_SUB) ? ~B : B;
            carry <= (mode == MODE_SUB) ? ~Cin : Cin;
            count <= '0;
            res   <= '0;
          end
        end
        SHIFT: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= co;
          res   <= res_nxt;
          if (count != LAST) begin
            count <= count + CW'(1);
          end else begin
            // On the MSB, carry holds carry-into-MSB and co is carry-out-of-MSB.
            S    <= res_nxt;
            Cout <= co;
            Ovf  <= carry ^ co;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub at WIDTH=8 and WIDTH=16 with an arithmetic reference
// model, per-cycle output checking and directed literal cases.
module tb_serial_addsub;

  localparam int W0 = 8;
  localparam int W1 = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_v[2];
  logic        mode_v[2];
  logic        cin_v[2];
  logic [63:0] a_v[2];
  logic [63:0] b_v[2];

  logic          busy8, done8, cout8, ovf8;
  logic [W0-1:0] s8;
  logic          busy16, done16, cout16, ovf16;
  logic [W1-1:0] s16;

  logic        busy_v[2], done_v[2], cout_v[2], ovf_v[2];
  logic [63:0] s_v[2];
  assign busy_v[0] = busy8;   assign busy_v[1] = busy16;
  assign done_v[0] = done8;   assign done_v[1] = done16;
  assign cout_v[0] = cout8;   assign cout_v[1] = cout16;
  assign ovf_v[0]  = ovf8;    assign ovf_v[1]  = ovf16;
  assign s_v[0]    = 64'(s8); assign s_v[1]    = 64'(s16);

  serial_addsub #(.WIDTH(W0)) dut8 (
    .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode_v[0]),
    .A(a_v[0][W0-1:0]), .B(b_v[0][W0-1:0]), .Cin(cin_v[0]),
    .busy(busy8), .done(done8), .S(s8), .Cout(cout8), .Ovf(ovf8)
  );

  serial_addsub #(.WIDTH(W1)) dut16 (
    .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode_v[1]),
    .A(a_v[1][W1-1:0]), .B(b_v[1][W1-1:0]), .Cin(cin_v[1]),
    .busy(busy16), .done(done16), .S(s16), .Cout(cout16), .Ovf(ovf16)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wid(input int i);
    return (i == 0) ? W0 : W1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: the arithmetic result of A+B+Cin or A-B-Cin, returned as {ovf, cout, s}.
  function automatic logic [65:0] ref_op(input int w, input logic [63:0] a, input logic [63:0] b,
                                         input logic cin, input logic mode);
    logic [63:0] mask, sv;
    longint ua, ub, ci, lim, sa, sb, r, res;
    logic c, o;
    mask = (64'd1 << w) - 64'd1;
    ua   = longint'(a & mask);
    ub   = longint'(b & mask);
    ci   = cin ? 1 : 0;
    lim  = longint'(1) << (w - 1);
    sa   = (ua >= lim) ? ua - 2 * lim : ua;
    sb   = (ub >= lim) ? ub - 2 * lim : ub;
    if (mode) begin
      res = ua - ub - ci;
      c   = (ua >= ub + ci);
      r   = sa - sb - ci;
    end else begin
      res = ua + ub + ci;
      c   = (res >= 2 * lim);
      r   = sa + sb + ci;
    end
    o  = (r < -lim) || (r >= lim);
    sv = 64'(res) & mask;
    return {o, c, sv};
  endfunction

  // Model state: accept edge index, earliest edge a new start can be taken,
  // pending results queue and the currently held expected outputs.
  int          acc[2];
  int          nfree[2];
  logic        act[2];
  logic [63:0] es[2];
  logic        ec[2], eo[2];
  logic [65:0] exp_q0[$];
  logic [65:0] exp_q1[$];

  initial begin
    for (int i = 0; i < 2; i++) begin
      acc[i] = 0; nfree[i] = 0; act[i] = 1'b0;
      es[i] = '0; ec[i] = 1'b0; eo[i] = 1'b0;
      start_v[i] = 1'b0; mode_v[i] = 1'b0; cin_v[i] = 1'b0;
      a_v[i] = '0; b_v[i] = '0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i]   <= 1'b0;
        es[i]    <= '0;
        ec[i]    <= 1'b0;
        eo[i]    <= 1'b0;
        nfree[i] <= cyc + 1;
        if (i == 0) exp_q0.delete(); else exp_q1.delete();
      end else begin
        if (act[i] && cyc == acc[i] + wid(i)) begin
          logic [65:0] r;
          r = (i == 0) ? ((exp_q0.size() > 0) ? exp_q0.pop_front() : '0)
                       : ((exp_q1.size() > 0) ? exp_q1.pop_front() : '0);
          es[i] <= r[63:0];
          ec[i] <= r[64];
          eo[i] <= r[65];
        end
        if (start_v[i] && cyc >= nfree[i]) begin
          acc[i]   <= cyc;
          act[i]   <= 1'b1;
          nfree[i] <= cyc + wid(i) + 2;
          if (i == 0) exp_q0.push_back(ref_op(wid(i), a_v[i], b_v[i], cin_v[i], mode_v[i]));
          else        exp_q1.push_back(ref_op(wid(i), a_v[i], b_v[i], cin_v[i], mode_v[i]));
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int  n;
        logic be, de;
        n  = cyc - 1;
        be = act[i] && (n >= acc[i]) && (n <= acc[i] + wid(i) - 1);
        de = act[i] && (n == acc[i] + wid(i));
        chk($sformatf("w%0d_busy", wid(i)), 64'(busy_v[i]), 64'(be));
        chk($sformatf("w%0d_done", wid(i)), 64'(done_v[i]), 64'(de));
        chk($sformatf("w%0d_S",    wid(i)), s_v[i], es[i]);
        chk($sformatf("w%0d_Cout", wid(i)), 64'(cout_v[i]), 64'(ec[i]));
        chk($sformatf("w%0d_Ovf",  wid(i)), 64'(ovf_v[i]), 64'(eo[i]));
      end
    end
  end

  // Drive an operation at the current negedge; returns at the negedge after the accepting edge.
  task automatic issue(input int i, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic mode);
    start_v[i] = 1'b1; a_v[i] = a; b_v[i] = b; cin_v[i] = cin; mode_v[i] = mode;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int limit, output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (!done_v[i] && lat < limit) begin
      if (busy_v[i]) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (!done_v[i]) chk($sformatf("w%0d_done_timeout", wid(i)), 64'(0), 64'(1));
  endtask

  task automatic directed(input string nm, input int i, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic mode,
                          input logic [63:0] xs, input logic xc, input logic xo);
    int lat, bn;
    issue(i, a, b, cin, mode);
    wait_done(i, 40, lat, bn);
    chk({nm, "_lat"},  64'(lat), 64'(wid(i)));
    chk({nm, "_busy"}, 64'(bn), 64'(wid(i)));
    chk({nm, "_S"},    s_v[i], xs);
    chk({nm, "_Cout"}, 64'(cout_v[i]), 64'(xc));
    chk({nm, "_Ovf"},  64'(ovf_v[i]), 64'(xo));
    @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bn, cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_S8",    s_v[0], 64'h0);
    chk("reset_busy8", 64'(busy_v[0]), 64'h0);
    chk("reset_done8", 64'(done_v[0]), 64'h0);
    chk("reset_Cout8", 64'(cout_v[0]), 64'h0);
    chk("reset_Ovf8",  64'(ovf_v[0]), 64'h0);
    chk("reset_S16",   s_v[1], 64'h0);
    chk_en = 1'b1;

    directed("add_5a_3c",  0, 64'h5A, 64'h3C, 1'b0, 1'b0, 64'h96, 1'b0, 1'b1);
    directed("add_ff_01",  0, 64'hFF, 64'h01, 1'b0, 1'b0, 64'h00, 1'b1, 1'b0);
    directed("add_ff_01c", 0, 64'hFF, 64'h01, 1'b1, 1'b0, 64'h01, 1'b1, 1'b0);
    directed("sub_10_20",  0, 64'h10, 64'h20, 1'b0, 1'b1, 64'hF0, 1'b0, 1'b0);
    directed("sub_80_01",  0, 64'h80, 64'h01, 1'b0, 1'b1, 64'h7F, 1'b1, 1'b1);

    // Start during SHIFT with new operands and flipped mode must be ignored.
    issue(0, 64'h03, 64'h04, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    issue(0, 64'hAA, 64'h55, 1'b1, 1'b1);
    wait_done(0, 40, lat, bn);
    chk("ign_lat", 64'(lat), 64'(W0 - 3));
    chk("ign_S",    s_v[0], 64'h07);
    chk("ign_Cout", 64'(cout_v[0]), 64'h0);
    chk("ign_Ovf",  64'(ovf_v[0]), 64'h0);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[0]) cnt++;
    end
    chk("ign_no_second_done", 64'(cnt), 64'h0);
    mode_v[0] = 1'b0;

    // Back-to-back with start held high.
    start_v[0] = 1'b1; a_v[0] = 64'h01; b_v[0] = 64'h01; cin_v[0] = 1'b0; mode_v[0] = 1'b0;
    wait_done(0, 40, lat, bn);
    chk("b2b_first_S", s_v[0], 64'h02);
    for (int r = 0; r < 3; r++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
        chk("b2b_hold_S", s_v[0], 64'h02);
      end while (!done_v[0] && cnt < 40);
      chk("b2b_interval", 64'(cnt), 64'(W0 + 2));
    end
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-operation, then an immediate new operation.
    issue(0, 64'h12, 64'h34, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(busy_v[0]), 64'h0);
    chk("rst_done", 64'(done_v[0]), 64'h0);
    chk("rst_S",    s_v[0], 64'h0);
    directed("add_7f_01", 0, 64'h7F, 64'h01, 1'b0, 1'b0, 64'h80, 1'b0, 1'b1);

    directed("add16_ffff_0001", 1, 64'hFFFF, 64'h0001, 1'b0, 1'b0, 64'h0000, 1'b1, 1'b0);
    directed("sub16_8000_0001", 1, 64'h8000, 64'h0001, 1'b0, 1'b1, 64'h7FFF, 1'b1, 1'b1);

    // Random operations; inputs are scrambled while busy to show they are latched.
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 1000; k++) begin
        issue(i, {$urandom, $urandom}, {$urandom, $urandom},
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        lat = 0;
        while (!done_v[i] && lat < wid(i) + 5) begin
          a_v[i] = {$urandom, $urandom};
          b_v[i] = {$urandom, $urandom};
          cin_v[i] = 1'($urandom_range(0, 1));
          mode_v[i] = 1'($urandom_range(0, 1));
          start_v[i] = ($urandom_range(0, 3) == 0);
          @(negedge clk);
          lat++;
        end
        start_v[i] = 1'b0;
        if (!done_v[i]) chk($sformatf("w%0d_rand_timeout", wid(i)), 64'(0), 64'(1));
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised bit-serial adder/subtractor built around a single one-bit full-adder cell and a registered carry.
- Operands of WIDTH bits are processed LSB-first, one bit per clock, under a start/busy/done handshake.
- Supports add and subtract modes, and reports carry-out and signed overflow.
- Serves as the area-minimal arithmetic unit for multi-bit datapaths and as the sequential successor to the combinational full-adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- mode  input  1  0 = add (A+B+Cin), 1 = subtract (A-B-Cin, Cin acts as borrow-in)
- A  input  WIDTH  operand A, sampled on accepted start
- B  input  WIDTH  operand B, sampled on accepted start
- Cin  input  1  carry-in (add) / borrow-in (sub), sampled on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when result registers update
- S  output  WIDTH  result, held until next completion
- Cout  output  1  raw carry out of MSB; in sub mode 1 = no borrow
- Ovf  output  1  two's-complement overflow of the operation

Behaviour:
- Reset (rst=1 at a rising edge): state IDLE; busy=0, done=0, S=0, Cout=0, Ovf=0; internal shift registers, carry and counter cleared. rst has priority over all other inputs.
- FSM states and transitions:
  - IDLE -> SHIFT on start=1.
  - SHIFT -> SHIFT while count < WIDTH-1.
  - SHIFT -> DONE after the WIDTH-th bit.
  - DONE -> IDLE unconditionally.
- Accept (edge k, IDLE and start=1):
  - opA <= A; opB <= mode ? ~B : B; carry <= mode ? ~Cin : Cin; count <= 0; msb info cleared.
  - Mode is latched; later changes to mode are ignored.
- Each SHIFT cycle:
  - sum = opA[0] ^ opB[0] ^ carry.
  - carry <= majority(opA[0], opB[0], carry).
  - Result shift register shifts right, with sum entering the MSB.
  - opA and opB shift right; count++.
- Overflow: on the last bit (count = WIDTH-1), capture carry-into-MSB. Ovf = carry-into-MSB XOR carry-out-of-MSB.
- DONE (entered after edge k+WIDTH):
  - S, Cout and Ovf load from the internal registers.
  - done=1 for exactly one cycle, visible in cycle k+WIDTH+1.
  - busy=0 in DONE.
- Latency: done visible WIDTH+1 cycles after the accepting edge. Minimum issue interval is WIDTH+2 cycles; with start held high, operations run back-to-back.
- Busy: busy=1 exactly in SHIFT, i.e. WIDTH cycles.
- Output stability: S, Cout and Ovf change only on entry to DONE or on reset. They are never exposed mid-computation.
- start in SHIFT or DONE: ignored, not queued.
- A, B and Cin changing after acceptance: no effect.
- rst mid-operation: the operation is aborted and done never pulses for it. Outputs go to 0 on the reset edge, and a fresh start is accepted in the first cycle after rst deasserts.
- Counter width is $clog2(WIDTH); no wrap beyond WIDTH-1.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - MODE_ADD=1'b0, MODE_SUB=1'b1.
- One sub-module, full_adder_bit: purely combinational 1-bit full adder (a, b, ci -> s, co). It is instantiated once in serial_addsub and is testable standalone.
- All sequential logic (FSM, shift registers, carry flop, counter, output registers) lives in serial_addsub.

Test Plan:
All scenarios use WIDTH=8 unless noted.
1. Add: mode=0, A=8'h5A, B=8'h3C, Cin=0, start pulse -> busy high 8 cycles; done at k+9; S=8'h96, Cout=0, Ovf=1.
2. Add with wrap: A=8'hFF, B=8'h01, Cin=0 -> S=8'h00, Cout=1, Ovf=0. Repeat with Cin=1 -> S=8'h01, Cout=1, Ovf=0.
3. Subtract: mode=1, A=8'h10, B=8'h20, Cin=0 -> S=8'hF0, Cout=0, Ovf=0. Then A=8'h80, B=8'h01 -> S=8'h7F, Cout=1, Ovf=1.
4. Ignored start and operand stability:
   - Accept A=8'h03, B=8'h04 (add).
   - At cycle k+3, pulse start with A=8'hAA, B=8'h55 and flip mode.
   - Expect a single done at k+9 with S=8'h07, Cout=0, Ovf=0.
   - No second done within the following 12 cycles.
5. Back-to-back and output hold:
   - Hold start=1 with A=8'h01, B=8'h01, Cin=0 -> done pulses every 10 cycles, S=8'h02 each time.
   - S is unchanged between done pulses.
6. Reset and width variation:
   - Assert rst for 1 cycle at k+4 of an add -> busy=0, S=0 the next cycle, no done.
   - A new op 8'h7F+8'h01 immediately after -> S=8'h80, Ovf=1.
   - Also rerun scenario 2 with WIDTH=16: A=16'hFFFF, B=16'h0001 -> S=16'h0000, Cout=1, done at k+17.
7. Randomised regression: 1000 random A/B/Cin/mode ops checked against a behavioural A±B±Cin model, for both WIDTH values.
